game_phase_sequencer: RTL and testbench
=======================================

Name: game_phase_sequencer

Overview:
- Master sequencer for the symbol-counting game. It produces the one-hot phase flags (lose, pre, game, answer, post) that select the seven-segment source in the display controller.
- Times every phase from a divided 1 Hz tick, latches the player's count, and computes the absolute difference from the game's count.
- Steps through four post-phase display pages, then either advances the level or freezes in LOSE.
- Sits between the button/debounce logic and the display mux.

Parameters:
- CLK_HZ, 100000000, clock cycles per 1 s tick
- PRE_SECS, 3, preliminary countdown length in ticks
- GAME_SECS, 10, symbol display length in ticks
- ANSWER_SECS, 15, answer entry timeout in ticks
- PAGE_SECS, 1, dwell per post page in ticks
- TOLERANCE, 2, maximum passing |user-game| difference
- MAX_LEVEL, 9, last level; passing it returns to IDLE with win set

Ports:
- Clk100M  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse (debounced); accepted only in IDLE
- submit  in  1  single-cycle pulse; accepted only in ANSWER
- userCount  in  8  player's running count (binary)
- gameCount  in  8  true symbol count for the current level (binary)
- pre, game, answer, post, lose  out  1 each  phase flags; at most one high
- postPage  out  2  page index during POST: 0=P count, 1=S count, 2=diff, 3=verdict
- passed  out  1  verdict latched at POST entry
- countDiff  out  8  |latched userCount - gameCount|
- userLatched  out  8  userCount captured at ANSWER exit
- level  out  4  current level, 0..MAX_LEVEL
- win  out  1  high in IDLE after clearing MAX_LEVEL; cleared by start
- secLeft  out  5  ticks remaining in current phase/page, for countdown display

Behaviour:
- Reset, synchronous, highest priority:
  - state=IDLE; all flags 0; postPage=0; passed=0; countDiff=0; userLatched=0; level=0; win=0; secLeft=0.
  - Tick divider and phase timer cleared.
  - Reset mid-phase returns to IDLE on the next edge.
- Tick divider: counts 0..CLK_HZ-1 and emits a one-cycle tick at CLK_HZ-1. It is cleared on every state or page transition, so each phase lasts exactly N*CLK_HZ cycles from entry.
- Flags are registered and decoded from state. A flag rises in the cycle after the transition edge (1-cycle latency).
- States and transitions:
  - IDLE: all flags 0. start -> PRE with secLeft=PRE_SECS; win cleared.
  - PRE: pre=1. secLeft decrements on each tick. The tick that takes secLeft from 1 to 0 -> GAME with secLeft=GAME_SECS.
  - GAME: game=1. Same countdown, then -> ANSWER with secLeft=ANSWER_SECS.
  - ANSWER: answer=1.
    - submit, or the final tick: userLatched<=userCount, countDiff<=abs difference (8-bit, no wrap), passed<=(countDiff<=TOLERANCE) -> POST, page 0, secLeft=PAGE_SECS.
    - submit on the same cycle as the final tick is treated as a single exit.
  - POST: post=1. Each page lasts PAGE_SECS ticks, then postPage increments. After page 3 expires:
    - passed=0 -> LOSE.
    - passed=1 and level<MAX_LEVEL -> level+1 -> PRE.
    - passed=1 and level==MAX_LEVEL -> level<=0, win<=1 -> IDLE.
  - LOSE: lose=1, all other flags 0. Terminal; start is ignored; only Reset exits.
- start or submit outside their accepting state: ignored, no side effect.
- userCount and gameCount are sampled only at ANSWER exit. Later changes do not alter countDiff or passed.
- Difference boundary values: 0 and 255 both handled without overflow. Difference equal to TOLERANCE passes.

Decomposition:
- Shared package holds:
  - the phase enum: IDLE, PRE, GAME, ANSWER, POST, LOSE (3-bit encoding);
  - the page index constants P_USER=0, P_GAME=1, P_DIFF=2, P_VERDICT=3.
- One natural sub-module: tick_divider (parameter CLK_HZ; inputs Clk100M, Reset, clear; output tick).

Test Plan (CLK_HZ=10, PRE_SECS=3, GAME_SECS=10, ANSWER_SECS=15, PAGE_SECS=1, TOLERANCE=2):
- Reset, then start at cycle 0 -> pre=1 from cycle 1 for 30 cycles; game=1 for 100 cycles; answer=1 after. Flags are one-hot every cycle.
- In ANSWER, userCount=12, gameCount=14, submit -> countDiff=2, passed=1. POST pages 0..3 at 10 cycles each; then level=1 and pre=1.
- userCount=20, gameCount=14, no submit -> ANSWER lasts 150 cycles; countDiff=6, passed=0. After page 3, lose=1 and stays 1 through 1000 further cycles and start pulses.
- userCount=0, gameCount=255 -> countDiff=255, passed=0. Reverse operands (255, 0) -> countDiff=255.
- Reset asserted mid-GAME -> next cycle all flags 0, level=0, secLeft=0. A subsequent start restarts PRE with full 30 cycles.
- Force level=MAX_LEVEL and pass -> after page 3: IDLE, win=1, level=0. Next start clears win and enters PRE. submit pulsed during PRE, GAME and POST has no effect.

Source files
------------

// File: rtl/game_phase_sequencer_pkg.sv
// Shared definitions for the game phase sequencer.
//   phase_e   : sequencer phases (3-bit encoding)
//   P_*       : post-phase display page indices
//   absDiff   : unsigned 8-bit absolute difference
package game_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    GAME   = 3'd2,
    ANSWER = 3'd3,
    POST   = 3'd4,
    LOSE   = 3'd5
  } phase_e;

  localparam logic [1:0] P_USER    = 2'd0;
  localparam logic [1:0] P_GAME    = 2'd1;
  localparam logic [1:0] P_DIFF    = 2'd2;
  localparam logic [1:0] P_VERDICT = 2'd3;

  // Larger minus smaller, so 0 and 255 never wrap.
  function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/game_phase_sequencer_tick_divider.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ cycles.
//   Clk100M : system clock
//   Reset   : synchronous active-high reset
//   clear   : restart the count (phase/page transition)
//   tick    : high for one cycle when the count reaches CLK_HZ-1
module tick_divider #(
  parameter int CLK_HZ = 100000000
) (
  input  logic Clk100M,
  input  logic Reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] Last = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == Last);

  always_ff @(posedge Clk100M) begin
    if (Reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/game_phase_sequencer.sv
// Master phase sequencer for the symbol-counting game.
//   Clk100M, Reset         : clock, synchronous active-high reset
//   start, submit          : debounced single-cycle button pulses
//   userCount, gameCount   : player's and true symbol counts
//   pre/game/answer/post/lose : registered one-hot phase flags
//   postPage               : display page while in POST
//   passed, countDiff, userLatched : verdict data captured at ANSWER exit
//   level, win             : progress through the levels
//   secLeft                : ticks remaining in the current phase/page
module game_phase_sequencer
  import game_phase_sequencer_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int PRE_SECS    = 3,
  parameter int GAME_SECS   = 10,
  parameter int ANSWER_SECS = 15,
  parameter int PAGE_SECS   = 1,
  parameter int TOLERANCE   = 2,
  parameter int MAX_LEVEL   = 9
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] userCount,
  input  logic [7:0] gameCount,
  output logic       pre,
  output logic       game,
  output logic       answer,
  output logic       post,
  output logic       lose,
  output logic [1:0] postPage,
  output logic       passed,
  output logic [7:0] countDiff,
  output logic [7:0] userLatched,
  output logic [3:0] level,
  output logic       win,
  output logic [4:0] secLeft
);

  localparam logic [4:0] PreS   = 5'(PRE_SECS);
  localparam logic [4:0] GameS  = 5'(GAME_SECS);
  localparam logic [4:0] AnsS   = 5'(ANSWER_SECS);
  localparam logic [4:0] PageS  = 5'(PAGE_SECS);
  localparam logic [7:0] Tol    = 8'(TOLERANCE);
  localparam logic [3:0] MaxLvl = 4'(MAX_LEVEL);

  phase_e     state, stateNxt;
  logic [1:0] pageNxt;
  logic [4:0] secNxt;
  logic [3:0] levelNxt;
  logic       winNxt;
  logic       latch;
  logic       clearDiv;
  logic       tick;
  logic       lastTick;
  logic [7:0] diffNow;

  assign diffNow  = absDiff(userCount, gameCount);
  assign lastTick = tick && (secLeft == 5'd1);

  tick_divider #(.CLK_HZ(CLK_HZ)) uDiv (
    .Clk100M (Clk100M),
    .Reset   (Reset),
    .clear   (clearDiv),
    .tick    (tick)
  );

  always_comb begin
    stateNxt = state;
    pageNxt  = postPage;
    secNxt   = secLeft;
    levelNxt = level;
    winNxt   = win;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNxt = PRE;
          secNxt   = PreS;
          winNxt   = 1'b0;
        end
      end
      PRE: begin
        if (lastTick) begin
          stateNxt = GAME;
          secNxt   = GameS;
        end else if (tick) secNxt = secLeft - 5'd1;
      end
      GAME: begin
        if (lastTick) begin
          stateNxt = ANSWER;
          secNxt   = AnsS;
        end else if (tick) secNxt = secLeft - 5'd1;
      end
      ANSWER: begin
        // submit and timeout on the same cycle collapse into one exit
        if (submit || lastTick) begin
          latch    = 1'b1;
          stateNxt = POST;
          pageNxt  = P_USER;
          secNxt   = PageS;
        end else if (tick) secNxt = secLeft - 5'd1;
      end
      POST: begin
        if (lastTick) begin
          if (postPage != P_VERDICT) begin
            pageNxt = postPage + 2'd1;
            secNxt  = PageS;
          end else begin
            pageNxt = P_USER;
            secNxt  = '0;
            if (!passed) stateNxt = LOSE;
            else if (level < MaxLvl) begin
              levelNxt = level + 4'd1;
              stateNxt = PRE;
              secNxt   = PreS;
            end else begin
              levelNxt = '0;
              winNxt   = 1'b1;
              stateNxt = IDLE;
            end
          end
        end else if (tick) secNxt = secLeft - 5'd1;
      end
      LOSE: ;
      default: stateNxt = IDLE;
    endcase
    // restart the second count on any phase or page change so every
    // interval is an exact multiple of CLK_HZ from its entry
    clearDiv = (stateNxt != state) || (pageNxt != postPage);
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state       <= IDLE;
      pre         <= 1'b0;
      game        <= 1'b0;
      answer      <= 1'b0;
      post        <= 1'b0;
      lose        <= 1'b0;
      postPage    <= P_USER;
      passed      <= 1'b0;
      countDiff   <= '0;
      userLatched <= '0;
      level       <= '0;
      win         <= 1'b0;
      secLeft     <= '0;
    end else begin
      state    <= stateNxt;
      // flags decode the next state so they align with the state register
      pre      <= (stateNxt == PRE);
      game     <= (stateNxt == GAME);
      answer   <= (stateNxt == ANSWER);
      post     <= (stateNxt == POST);
      lose     <= (stateNxt == LOSE);
      postPage <= pageNxt;
      level    <= levelNxt;
      win      <= winNxt;
      secLeft  <= secNxt;
      if (latch) begin
        userLatched <= userCount;
        countDiff   <= diffNow;
        passed      <= (diffNow <= Tol);
      end
    end
  end

endmodule

// File: tb/tb_game_phase_sequencer.sv
module tb_game_phase_sequencer;

  localparam int CLK_HZ      = 10;
  localparam int PRE_SECS    = 3;
  localparam int GAME_SECS   = 10;
  localparam int ANSWER_SECS = 15;
  localparam int PAGE_SECS   = 1;
  localparam int TOLERANCE   = 2;
  localparam int MAX_LEVEL   = 9;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_PRE  = 5'b00001;
  localparam logic [4:0] F_GAME = 5'b00010;
  localparam logic [4:0] F_ANS  = 5'b00100;
  localparam logic [4:0] F_POST = 5'b01000;
  localparam logic [4:0] F_LOSE = 5'b10000;

  logic       Clk100M = 1'b0;
  logic       Reset   = 1'b0;
  logic       start   = 1'b0;
  logic       submit  = 1'b0;
  logic [7:0] userCount = '0;
  logic [7:0] gameCount = '0;
  logic       pre, game, answer, post, lose, passed, win;
  logic [1:0] postPage;
  logic [7:0] countDiff, userLatched;
  logic [3:0] level;
  logic [4:0] secLeft;
  logic [4:0] flags;

  int errCnt = 0;
  int chkCnt = 0;
  int expLevel = 0;
  bit expWin = 1'b0;

  assign flags = {lose, post, answer, game, pre};

  game_phase_sequencer #(
    .CLK_HZ(CLK_HZ), .PRE_SECS(PRE_SECS), .GAME_SECS(GAME_SECS),
    .ANSWER_SECS(ANSWER_SECS), .PAGE_SECS(PAGE_SECS),
    .TOLERANCE(TOLERANCE), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .Clk100M(Clk100M), .Reset(Reset), .start(start), .submit(submit),
    .userCount(userCount), .gameCount(gameCount),
    .pre(pre), .game(game), .answer(answer), .post(post), .lose(lose),
    .postPage(postPage), .passed(passed), .countDiff(countDiff),
    .userLatched(userLatched), .level(level), .win(win), .secLeft(secLeft)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      if (errCnt <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic checkRst(input string tag);
    chk({tag, " flags"}, flags, F_NONE);
    chk({tag, " postPage"}, postPage, 0);
    chk({tag, " passed"}, passed, 0);
    chk({tag, " countDiff"}, countDiff, 0);
    chk({tag, " userLatched"}, userLatched, 0);
    chk({tag, " level"}, level, 0);
    chk({tag, " win"}, win, 0);
    chk({tag, " secLeft"}, secLeft, 0);
  endtask

  task automatic doReset(input string tag);
    start = 0; submit = 0;
    Reset = 1; step(); step(); Reset = 0;
    expLevel = 0; expWin = 0;
    checkRst(tag);
  endtask

  task automatic doStart();
    start = 1; step(); start = 0;
    expWin = 0;
  endtask

  // A countdown phase: flag held for secs*CLK_HZ cycles, secLeft counting
  // down once per CLK_HZ cycles; stray button pulses must be ignored.
  task automatic timedPhase(input string tag, input logic [4:0] f, input int secs,
                            input int resetAt, output bit aborted);
    aborted = 0;
    for (int i = 0; i < secs * CLK_HZ; i++) begin
      chk({tag, " flags"}, flags, f);
      chk({tag, " secLeft"}, secLeft, secs - i / CLK_HZ);
      chk({tag, " level"}, level, expLevel);
      chk({tag, " win"}, win, expWin);
      if (i == resetAt) begin
        start = 0; submit = 0;
        Reset = 1; step(); Reset = 0;
        aborted = 1;
        return;
      end
      start  = ($urandom_range(0, 5) == 0);
      submit = ($urandom_range(0, 5) == 0);
      step();
    end
    start = 0; submit = 0;
  endtask

  // One level from the first PRE cycle through the end of POST page 3.
  // submitAt outside the answer window means "let it time out".
  task automatic playLevel(input logic [7:0] uc, input logic [7:0] gc, input int submitAt,
                           input int resetAt, output bit aborted);
    bit pass;
    int d, ansLen, pageCyc;
    timedPhase("pre", F_PRE, PRE_SECS, -1, aborted);
    timedPhase("game", F_GAME, GAME_SECS, resetAt, aborted);
    if (aborted) return;
    userCount = uc; gameCount = gc;
    ansLen = (submitAt >= 0 && submitAt < ANSWER_SECS * CLK_HZ) ? submitAt + 1
                                                                : ANSWER_SECS * CLK_HZ;
    for (int i = 0; i < ansLen; i++) begin
      chk("ans flags", flags, F_ANS);
      chk("ans secLeft", secLeft, ANSWER_SECS - i / CLK_HZ);
      submit = (i == submitAt);
      step();
    end
    submit = 0;
    // inputs after the exit must not affect the latched verdict
    userCount = 8'($urandom); gameCount = 8'($urandom);
    d = (int'(uc) > int'(gc)) ? int'(uc) - int'(gc) : int'(gc) - int'(uc);
    pass = (d <= TOLERANCE);
    pageCyc = PAGE_SECS * CLK_HZ;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < pageCyc; c++) begin
        chk("post flags", flags, F_POST);
        chk("post page", postPage, p);
        chk("post secLeft", secLeft, PAGE_SECS - c / CLK_HZ);
        chk("post countDiff", countDiff, d);
        chk("post passed", passed, pass);
        chk("post userLatched", userLatched, uc);
        chk("post level", level, expLevel);
        start  = ($urandom_range(0, 5) == 0);
        submit = ($urandom_range(0, 5) == 0);
        step();
      end
    end
    start = 0; submit = 0;
    if (pass) begin
      if (expLevel < MAX_LEVEL) expLevel++;
      else begin expLevel = 0; expWin = 1; end
    end
  endtask

  task automatic checkIdle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, " flags"}, flags, F_NONE);
      chk({tag, " level"}, level, expLevel);
      chk({tag, " win"}, win, expWin);
      submit = ($urandom_range(0, 3) == 0);
      step();
    end
    submit = 0;
  endtask

  task automatic checkLose(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, " flags"}, flags, F_LOSE);
      start  = ($urandom_range(0, 4) == 0);
      submit = ($urandom_range(0, 4) == 0);
      step();
    end
    start = 0; submit = 0;
  endtask

  initial begin
    bit ab;
    int off;
    logic [7:0] gc, uc;

    doReset("reset");
    checkIdle("idle", 20);

    // level 0 pass at exactly the tolerance, then abort mid-GAME of level 1
    doStart();
    playLevel(8'd12, 8'd14, $urandom_range(0, 149), -1, ab);
    playLevel(8'($urandom), 8'($urandom), 5, $urandom_range(0, GAME_SECS * CLK_HZ - 1), ab);
    chk("midreset aborted", ab, 1);
    expLevel = 0; expWin = 0;
    checkRst("midreset");

    // full climb through MAX_LEVEL with passing answers, some by timeout
    doStart();
    for (int lvl = 0; lvl <= MAX_LEVEL; lvl++) begin
      gc  = 8'($urandom_range(2, 253));
      off = int'($urandom_range(0, 4)) - 2;
      uc  = 8'(int'(gc) + off);
      playLevel(uc, gc, $urandom_range(0, 165), -1, ab);
    end
    checkIdle("win", 20);

    // restart clears win; boundary 0 vs 255 loses
    doStart();
    playLevel(8'd0, 8'd255, $urandom_range(0, 149), -1, ab);
    checkLose("lose0_255", 1000);

    // timeout with diff 6
    doReset("reset2");
    doStart();
    playLevel(8'd20, 8'd14, -1, -1, ab);
    checkLose("lose20_14", 50);

    // reverse boundary operands
    doReset("reset3");
    doStart();
    playLevel(8'd255, 8'd0, $urandom_range(0, 149), -1, ab);
    checkLose("lose255_0", 50);

    // one past tolerance fails
    doReset("reset4");
    doStart();
    playLevel(8'd17, 8'd14, $urandom_range(0, 149), -1, ab);
    checkLose("lose17_14", 50);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
